// File: rtl/sprite_bank_controller.sv
// Sprite bank controller: double-buffered per-sprite registers feeding a 2-stage hit/priority pipeline.
// Define SPRITE_COLLISION_EN to build the sticky per-frame collision flag; otherwise oCollision is 0.
module sprite_bank_controller #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SIZE_X      = 32,
  parameter int unsigned SIZE_Y      = 32,
  parameter int unsigned COLOR_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         iColumnCount,
  input  logic [9:0]         iRowCount,
  input  logic               iFrameStart,
  input  logic [COLOR_W-1:0] iColorBack,
  input  logic               iWrEn,
  input  logic [2:0]         iWrIdx,
  input  logic [9:0]         iWrPosX,
  input  logic [9:0]         iWrPosY,
  input  logic [COLOR_W-1:0] iWrColor,
  input  logic               iWrVisible,
  output logic [COLOR_W-1:0] oRGB,
  output logic               oHit,
  output logic [2:0]         oHitIdx,
  output logic               oCollision
);

  localparam int NS = int'(NUM_SPRITES);

  typedef struct packed {
    logic [9:0]         pos_x;
    logic [9:0]         pos_y;
    logic [COLOR_W-1:0] color;
    logic               visible;
  } sprite_t;

  sprite_t [NS-1:0]                shadow_q, shadow_d;
  sprite_t [NS-1:0]                active_q, active_d;
  logic    [NS-1:0]                s1_hit_q, s1_hit_d;
  logic    [NS-1:0][COLOR_W-1:0]   s1_color_q, s1_color_d;
  logic    [COLOR_W-1:0]           s1_bg_q;
  logic    [COLOR_W-1:0]           rgb_q, rgb_d;
  logic                            hit_q, hit_d;
  logic    [2:0]                   idx_q, idx_d;
  logic    [10:0]                  col_w, row_w;

  assign col_w = {1'b0, iColumnCount};
  assign row_w = {1'b0, iRowCount};

  // Active takes the pre-write shadow, so a coincident write lands only in shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = iFrameStart ? shadow_q : active_q;
    for (int i = 0; i < NS; i++) begin
      if (iWrEn && (iWrIdx == 3'(i))) begin
        shadow_d[i].pos_x   = iWrPosX;
        shadow_d[i].pos_y   = iWrPosY;
        shadow_d[i].color   = iWrColor;
        shadow_d[i].visible = iWrVisible;
      end
    end
  end

  // Stage 1 looks at the post-edge active set so a commit applies from the pixel sampled with it.
  always_comb begin
    s1_hit_d   = '0;
    s1_color_d = '0;
    for (int i = 0; i < NS; i++) begin
      s1_hit_d[i] = active_d[i].visible
                  && (col_w >= {1'b0, active_d[i].pos_x})
                  && (col_w <  ({1'b0, active_d[i].pos_x} + 11'(SIZE_X)))
                  && (row_w >= {1'b0, active_d[i].pos_y})
                  && (row_w <  ({1'b0, active_d[i].pos_y} + 11'(SIZE_Y)));
      s1_color_d[i] = active_d[i].color;
    end
  end

  // Descending scan so the lowest covering index is the last (winning) assignment.
  always_comb begin
    rgb_d = s1_bg_q;
    hit_d = 1'b0;
    idx_d = 3'd0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        rgb_d = s1_color_q[i];
        hit_d = 1'b1;
        idx_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      s1_hit_q   <= '0;
      s1_color_q <= '0;
      s1_bg_q    <= '0;
      rgb_q      <= '0;
      hit_q      <= 1'b0;
      idx_q      <= 3'd0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      s1_hit_q   <= s1_hit_d;
      s1_color_q <= s1_color_d;
      s1_bg_q    <= iColorBack;
      rgb_q      <= rgb_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
    end
  end

  assign oRGB    = rgb_q;
  assign oHit    = hit_q;
  assign oHitIdx = idx_q;

`ifdef SPRITE_COLLISION_EN
  logic coll_q, coll_d, multi_hit;

  // Clearing bit-trick: nonzero after removing the lowest set bit means two or more hits.
  always_comb begin
    multi_hit = (s1_hit_q & (s1_hit_q - NS'(1))) != '0;
    coll_d    = iFrameStart ? 1'b0 : (coll_q | multi_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign oCollision = coll_q;
`else
  assign oCollision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_bank_controller.sv
// Testbench for sprite_bank_controller: directed scenarios plus random traffic vs a frame-level model.
// Collision expectations follow SPRITE_COLLISION_EN when the bench is built with it.
module tb_sprite_bank_controller;

  localparam int NS = 4;
  localparam int SX = 32;
  localparam int SY = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] col = '0, row = '0;
  logic       fs = 1'b0;
  logic [2:0] bg = '0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [9:0] wr_x = '0, wr_y = '0;
  logic [2:0] wr_color = '0;
  logic       wr_vis = 1'b0;
  logic [2:0] rgb;
  logic       hit;
  logic [2:0] hit_idx;
  logic       coll;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: shadow/active sprite tables, one in-flight pixel, and the expected outputs.
  int sh_x[NS], sh_y[NS], sh_c[NS];
  bit sh_v[NS];
  int ac_x[NS], ac_y[NS], ac_c[NS];
  bit ac_v[NS];
  int s1_rgb, s1_idx, s1_cnt;
  bit s1_hit;
  int e_rgb, e_idx;
  bit e_hit, e_coll;

  sprite_bank_controller #(
    .NUM_SPRITES(NS), .SIZE_X(SX), .SIZE_Y(SY), .COLOR_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iColumnCount(col), .iRowCount(row), .iFrameStart(fs), .iColorBack(bg),
    .iWrEn(wr_en), .iWrIdx(wr_idx), .iWrPosX(wr_x), .iWrPosY(wr_y),
    .iWrColor(wr_color), .iWrVisible(wr_vis),
    .oRGB(rgb), .oHit(hit), .oHitIdx(hit_idx), .oCollision(coll)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_c[i] = 0; sh_v[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_c[i] = 0; ac_v[i] = 0;
    end
    s1_rgb = 0; s1_idx = 0; s1_cnt = 0; s1_hit = 0;
    e_rgb = 0; e_idx = 0; e_hit = 0; e_coll = 0;
  endtask

  // Apply one pixel (and optional write / frame start) across one rising edge, then update the model.
  task automatic tick(input int c, input int r, input bit f, input bit w, input int wi,
                      input int wx, input int wy, input int wc, input bit wv);
    int win;
    col = 10'(c); row = 10'(r); fs = f;
    wr_en = w; wr_idx = 3'(wi); wr_x = 10'(wx); wr_y = 10'(wy); wr_color = 3'(wc); wr_vis = wv;
    @(posedge clk);
`ifdef SPRITE_COLLISION_EN
    e_coll = f ? 1'b0 : (e_coll || (s1_cnt >= 2));
`else
    e_coll = 1'b0;
`endif
    e_rgb = s1_rgb; e_hit = s1_hit; e_idx = s1_idx;
    if (f) begin
      for (int i = 0; i < NS; i++) begin
        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_c[i] = sh_c[i]; ac_v[i] = sh_v[i];
      end
    end
    win = -1;
    s1_cnt = 0;
    for (int i = 0; i < NS; i++) begin
      if (ac_v[i] && c >= ac_x[i] && c < ac_x[i] + SX && r >= ac_y[i] && r < ac_y[i] + SY) begin
        s1_cnt++;
        if (win < 0) win = i;
      end
    end
    s1_hit = (win >= 0);
    s1_idx = s1_hit ? win : 0;
    s1_rgb = s1_hit ? ac_c[win] : int'(bg);
    if (w && wi < NS) begin
      sh_x[wi] = wx; sh_y[wi] = wy; sh_c[wi] = wc; sh_v[wi] = wv;
    end
    @(negedge clk);
    fs = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rgb, hit, hit_idx, coll} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_immediate got rgb=%0d hit=%0d idx=%0d coll=%0d want all 0",
               rgb, hit, hit_idx, coll);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    bg = 3'd6;
    for (int k = 0; k < 4; k++) begin
      tick(k * 7, k * 3, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL reset_pipeline got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  task automatic test_shadow_no_commit();
    bg = 3'd5;
    tick(0, 0, 0, 1, 0, 100, 50, 4, 1);
    for (int k = 0; k < 4; k++) begin
      tick(100, 50, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL shadow_only got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  task automatic test_commit();
    int pc[10] = '{100, 100, 132, 99, 131, 131, 100, 100, 0, 0};
    int pr[10] = '{ 50,  50,  50, 50,  81,  82,  49,  50, 0, 0};
    bg = 3'd5;
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick(pc[k], pr[k], 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL commit_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  task automatic test_priority_collision();
    int pc[10] = '{200, 200, 200, 200, 0, 0, 0, 0, 0, 0};
    bit pf[10] = '{  0,   0,   0,   0, 0, 0, 1, 0, 0, 0};
    bg = 3'd7;
    tick(0, 0, 0, 1, 1, 190, 190, 2, 1);
    tick(0, 0, 0, 1, 2, 195, 195, 1, 1);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick(pc[k], pc[k], pf[k], 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL priority_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  task automatic test_no_wrap();
    bg = 3'd1;
    tick(0, 0, 0, 1, 3, 1010, 0, 6, 1);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 28; k++) begin
      int c;
      int r;
      c = (k < 21) ? k : ((k == 21) ? 1015 : ((k == 22) ? 1009 : 1023));
      r = (k == 24) ? 31 : ((k == 25) ? 32 : 0);
      if (k >= 24) c = 1012;
      tick(c, r, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL no_wrap_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  task automatic test_write_with_frame();
    int pc[12] = '{100, 300, 100, 300, 0, 0, 300, 300, 100, 100, 0, 0};
    bit pf[12] = '{  0,   0,   0,   0, 0, 1,   0,   0,   0,   0, 0, 0};
    bg = 3'd2;
    tick(0, 0, 1, 1, 0, 300, 300, 7, 1);
    for (int k = 0; k < 12; k++) begin
      int r;
      r = (pc[k] == 100) ? 50 : pc[k];
      tick(pc[k], r, pf[k], 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL wr_frame_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int pc[6] = '{300, 200, 1015, 100, 300, 300};
    int pr[6] = '{300, 200,    0,  50, 300, 300};
    bg = 3'd3;
    repeat (3) tick(300, 300, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rgb, hit, hit_idx, coll} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_midframe got rgb=%0d hit=%0d idx=%0d coll=%0d want all 0",
               rgb, hit, hit_idx, coll);
    end
    #1 rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      tick(pc[k], pr[k], 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL after_reset_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
    tick(0, 0, 0, 1, 0, 300, 300, 4, 1);
    tick(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(310, 310, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL recommit_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  function automatic int pick_coord();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                       : int'($urandom_range(0, 159));
  endfunction

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      bit f;
      bit w;
      f = ($urandom_range(0, 15) == 0);
      w = ($urandom_range(0, 5) == 0);
      bg = 3'($urandom_range(0, 7));
      tick(pick_coord(), pick_coord(), f, w, int'($urandom_range(0, 7)), pick_coord(),
           pick_coord(), int'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0));
      n_vec++;
      if ({rgb, hit, hit_idx, coll} !== {3'(e_rgb), e_hit, 3'(e_idx), e_coll}) begin
        n_err++;
        $display("FAIL random_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 k, rgb, hit, hit_idx, coll, e_rgb, e_hit, e_idx, e_coll);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_shadow_no_commit();
    test_commit();
    test_priority_collision();
    test_no_wrap();
    test_write_with_frame();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_bank_controller.md
SPRITE_BANK_CONTROLLER -- requirements
Module: sprite_bank_controller

Interface
REQ-001 Parameter NUM_SPRITES, default 4, number of independent sprite channels (1..8).
REQ-002 Parameter SIZE_X, default 32, sprite width in pixels.
REQ-003 Parameter SIZE_Y, default 32, sprite height in pixels.
REQ-004 Parameter COLOR_W, default 3, RGB color width.
REQ-005 Clock  input  1  single clock; all logic on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 iColumnCount  input  10  current pixel column from the VGA timing generator.
REQ-008 iRowCount  input  10  current pixel row.
REQ-009 iFrameStart  input  1  one-cycle strobe at the start of vertical blank.
REQ-010 iColorBack  input  COLOR_W  background color.
REQ-011 iWrEn  input  1  shadow-register write strobe.
REQ-012 iWrIdx  input  3  sprite index to write.
REQ-013 iWrPosX, iWrPosY  input  10 each  new sprite top-left position.
REQ-014 iWrColor  input  COLOR_W  new sprite color.
REQ-015 iWrVisible  input  1  new sprite enable.
REQ-016 oRGB  output  COLOR_W  registered pixel color.
REQ-017 oHit  output  1  registered: some visible sprite covers the pixel.
REQ-018 oHitIdx  output  3  registered: index of the winning sprite (0 when oHit=0).
REQ-019 oCollision  output  1  sticky per-frame collision flag (see Configuration).

Function
REQ-020 Each sprite SHALL hold a shadow register set (PosX, PosY, Color, Visible) and an active register set.
REQ-021 iWrEn=1 with iWrIdx<NUM_SPRITES SHALL update that sprite's shadow set on the same edge; iWrIdx>=NUM_SPRITES SHALL be ignored.
REQ-022 iFrameStart=1 SHALL copy all shadow sets to active sets on that edge; only the active sets drive pixel output (tear-free update).
REQ-023 On simultaneous iFrameStart and iWrEn, active SHALL receive the pre-write shadow value; the write SHALL land in shadow and take effect at the next iFrameStart.
REQ-024 Sprite i covers pixel when Visible=1, PosX<=col<PosX+SIZE_X and PosY<=row<PosY+SIZE_Y, half-open bounds.
REQ-025 Bound sums SHALL be computed at 11 bits; no 10-bit wrap-around, so a sprite at PosX=1010 covers columns 1010..1023 only.
REQ-026 Pipeline stage 1 SHALL register the per-sprite hit vector and the pixel's background color; stage 2 SHALL priority-select and register the outputs.
REQ-027 Total latency SHALL be exactly 2 cycles from iColumnCount/iRowCount to oRGB/oHit/oHitIdx.
REQ-028 Priority: the lowest-index covering sprite SHALL win; oRGB = its active Color, else the 2-cycle-delayed iColorBack.
REQ-029 Active-set changes at iFrameStart SHALL affect only pixels sampled at or after that edge.

Reset
REQ-030 Reset low SHALL immediately clear all shadow and active sets to PosX=0, PosY=0, Color=0, Visible=0.
REQ-031 Reset low SHALL immediately force oRGB=0, oHit=0, oHitIdx=0, oCollision=0, and clear both pipeline stages.
REQ-032 Reset deassertion mid-frame SHALL produce background-only output: no sprite is visible until written and committed by an iFrameStart.

Configuration
REQ-033 Macro SPRITE_COLLISION_EN defined: oCollision SHALL set one cycle after stage 1 registers two or more hits (aligned with stage 2).
REQ-034 With SPRITE_COLLISION_EN, oCollision SHALL stay set until iFrameStart, which clears it; if a collision and iFrameStart coincide, the clear wins.
REQ-035 Macro undefined: oCollision SHALL be tied to 0 and no collision logic SHALL be synthesised.

Verification
REQ-036 Sprite 0 written to (100,50), color 3'b100, visible; no iFrameStart follows -> oRGB stays iColorBack at (100,50).
REQ-037 Same stimulus plus iFrameStart -> at (100,50) oRGB=3'b100, oHit=1, oHitIdx=0 two cycles later; at (132,50) and (99,50) oRGB=background.
REQ-038 Sprites 1 and 2 both cover (200,200) with colors 3'b010 and 3'b001 -> oRGB=3'b010, oHitIdx=1; with SPRITE_COLLISION_EN, oCollision=1 until the next iFrameStart.
REQ-039 Sprite 3 at PosX=1010, PosY=0 -> column 1015 hit; columns 0..20 of row 0 show no hit (no wrap).
REQ-040 iWrEn to sprite 0 at (300,300) on the same edge as iFrameStart -> the old position stays active for that frame; the new one is active after the following iFrameStart.
REQ-041 Reset pulsed low mid-frame with sprites visible -> all outputs 0 immediately; after release oHit=0 everywhere until a write and commit.
